// File: rtl/gray_seq_pkg.sv
// Shared types and helpers for the Gray-code sequencer.
// Holds the state encoding, direction constants and the binary-to-Gray function.
package gray_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Reflected binary code; callers zero-extend and truncate to their own width.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/bin_to_gray_enc.sv
// Combinational WIDTH-bit binary-to-Gray encoder (WIDTH up to 32).
module bin_to_gray_enc
  import gray_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_bin,
  output logic [WIDTH-1:0] o_gray
);

  assign o_gray = WIDTH'(bin2gray(32'(i_bin)));

endmodule

// File: rtl/gray_seq_ctrl.sv
// Start/stop sequencer that steps a binary count and streams its Gray code
// over a valid/ready handshake, with preload, direction and optional wrap.
module gray_seq_ctrl
  import gray_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             dir,
  input  logic             wrap_en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             Gc_ready,
  output logic             Gc_valid,
  output logic [WIDTH-1:0] Gc_output,
  output logic [WIDTH-1:0] Bin_count,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_MIN = {WIDTH{1'b0}};

  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic             r_dir;
  logic             r_wrap;
  logic             r_stop_pend;

  logic             w_xfer;
  logic             w_term;
  logic [WIDTH-1:0] w_next;

  // Modulo arithmetic gives the wrap value for free when wrapping is enabled.
  assign w_xfer = (r_state == ST_RUN) && Gc_ready;
  assign w_term = (r_dir == DIR_DOWN) ? (r_count == CNT_MIN) : (r_count == CNT_MAX);
  assign w_next = (r_dir == DIR_DOWN) ? (r_count - WIDTH'(1)) : (r_count + WIDTH'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_count     <= CNT_MIN;
      r_dir       <= DIR_UP;
      r_wrap      <= 1'b0;
      r_stop_pend <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (load) begin
            r_count <= load_val;
          end else if (start && !stop) begin
            r_state <= ST_RUN;
            r_dir   <= dir;
            r_wrap  <= wrap_en;
          end
        end
        ST_RUN: begin
          if (w_xfer) begin
            // Terminal without wrap takes priority over a pending stop.
            if (w_term && !r_wrap) begin
              r_state <= ST_DONE;
            end else begin
              r_count <= w_next;
              if (stop || r_stop_pend) begin
                r_state <= ST_IDLE;
              end
            end
            r_stop_pend <= 1'b0;
          end else if (stop) begin
            r_stop_pend <= 1'b1;
          end
        end
        ST_DONE: begin
          if (load) begin
            r_count <= load_val;
            r_state <= ST_IDLE;
          end else if (start && !stop) begin
            r_state <= ST_RUN;
            r_dir   <= dir;
            r_wrap  <= wrap_en;
            r_count <= (dir == DIR_DOWN) ? CNT_MAX : CNT_MIN;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_stop_pend <= 1'b0;
        end
      endcase
    end
  end

  bin_to_gray_enc #(.WIDTH(WIDTH)) u_enc (
    .i_bin  (r_count),
    .o_gray (Gc_output)
  );

  assign Bin_count = r_count;
  assign Gc_valid  = (r_state == ST_RUN);
  assign busy      = (r_state == ST_RUN);
  assign done      = (r_state == ST_DONE);

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// Scoreboard bench for gray_seq_ctrl: stimulus queues expected codes,
// a negedge monitor pops them on every handshake.
module tb_gray_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       dir = 1'b0;
  logic       wrap_en = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic       Gc_ready = 1'b0;
  logic       Gc_valid;
  logic [3:0] Gc_output;
  logic [3:0] Bin_count;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_errors = 0;
  logic [3:0] exp_q[$];

  gray_seq_ctrl #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .dir       (dir),
    .wrap_en   (wrap_en),
    .load      (load),
    .load_val  (load_val),
    .Gc_ready  (Gc_ready),
    .Gc_valid  (Gc_valid),
    .Gc_output (Gc_output),
    .Bin_count (Bin_count),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted transfer must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && Gc_valid && Gc_ready) begin
      if (exp_q.size() == 0) begin
        chk("xfer_unexpected", {28'd0, Gc_output}, 32'hFFFF_FFFF);
      end else begin
        chk("xfer_code", {28'd0, Gc_output}, {28'd0, exp_q.pop_front()});
      end
    end
  end

  logic [3:0] up_codes [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111,
                               4'b0101, 4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110,
                               4'b1010, 4'b1011, 4'b1001, 4'b1000};
  logic [3:0] dn_codes [8]  = '{4'b0111, 4'b0110, 4'b0010, 4'b0011, 4'b0001, 4'b0000,
                               4'b1000, 4'b1001};

  initial begin
    // Reset state
    tick();
    chk("rst_valid", Gc_valid, 1'b0);
    chk("rst_count", Bin_count, 4'd0);
    chk("rst_gray", Gc_output, 4'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    rst = 1'b0;

    // Full up count without wrap, ending in DONE
    load = 1'b1; load_val = 4'd0; tick(); load = 1'b0;
    foreach (up_codes[i]) exp_q.push_back(up_codes[i]);
    start = 1'b1; dir = 1'b0; wrap_en = 1'b0; Gc_ready = 1'b1; tick(); start = 1'b0;
    chk("run_first_valid", Gc_valid, 1'b1);
    for (int i = 0; i < 16; i++) tick();
    Gc_ready = 1'b0;
    chk("term_done", done, 1'b1);
    chk("term_valid", Gc_valid, 1'b0);
    chk("term_count", Bin_count, 4'hF);

    // Start from DONE going down reloads max, then stop back to IDLE
    start = 1'b1; dir = 1'b1; tick(); start = 1'b0;
    chk("done_restart_count", Bin_count, 4'hF);
    chk("done_restart_gray", Gc_output, 4'b1000);
    stop = 1'b1; tick(); stop = 1'b0;
    exp_q.push_back(4'b1000);
    Gc_ready = 1'b1; tick(); Gc_ready = 1'b0;
    chk("stop_from_max_count", Bin_count, 4'hE);
    chk("stop_from_max_busy", busy, 1'b0);

    // Down count with wrap from preload 0101
    load = 1'b1; load_val = 4'b0101; tick(); load = 1'b0;
    foreach (dn_codes[i]) exp_q.push_back(dn_codes[i]);
    start = 1'b1; dir = 1'b1; wrap_en = 1'b1; Gc_ready = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("wrap_busy", busy, 1'b1);
    end
    Gc_ready = 1'b0;

    // Stop while stalled: held code transfers, then IDLE at advanced count
    stop = 1'b1; tick(); stop = 1'b0;
    chk("stop_pend_valid", Gc_valid, 1'b1);
    chk("stop_pend_gray", Gc_output, 4'b1011);
    exp_q.push_back(4'b1011);
    Gc_ready = 1'b1; tick(); Gc_ready = 1'b0;
    chk("stop_idle_valid", Gc_valid, 1'b0);
    chk("stop_idle_count", Bin_count, 4'd12);
    start = 1'b1; dir = 1'b0; tick(); start = 1'b0;
    chk("resume_valid", Gc_valid, 1'b1);
    chk("resume_gray", Gc_output, 4'b1010);
    exp_q.push_back(4'b1010);
    stop = 1'b1; Gc_ready = 1'b1; tick(); stop = 1'b0; Gc_ready = 1'b0;
    chk("stop_direct_busy", busy, 1'b0);
    chk("stop_direct_count", Bin_count, 4'd13);

    // Backpressure at count 0011
    load = 1'b1; load_val = 4'b0011; tick(); load = 1'b0;
    start = 1'b1; dir = 1'b0; wrap_en = 1'b0; tick(); start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", Gc_valid, 1'b1);
      chk("stall_gray", Gc_output, 4'b0010);
    end
    exp_q.push_back(4'b0010);
    Gc_ready = 1'b1; tick(); Gc_ready = 1'b0;
    chk("after_stall_gray", Gc_output, 4'b0110);

    // Advance to 0110 then reset mid-RUN while stalled
    exp_q.push_back(4'b0110);
    exp_q.push_back(4'b0111);
    Gc_ready = 1'b1; tick(); tick(); Gc_ready = 1'b0;
    chk("pre_rst_count", Bin_count, 4'b0110);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("midrun_rst_valid", Gc_valid, 1'b0);
    chk("midrun_rst_count", Bin_count, 4'd0);
    chk("midrun_rst_gray", Gc_output, 4'd0);
    chk("midrun_rst_busy", busy, 1'b0);
    chk("midrun_rst_done", done, 1'b0);

    // IDLE priority: stop beats start, load beats start
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    chk("start_stop_busy", busy, 1'b0);
    chk("start_stop_valid", Gc_valid, 1'b0);
    load = 1'b1; start = 1'b1; load_val = 4'b1010; tick(); load = 1'b0; start = 1'b0;
    chk("load_start_count", Bin_count, 4'b1010);
    chk("load_start_busy", busy, 1'b0);

    tick();
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
